palette_ctrl: RTL and testbench

PALETTE_CTRL -- requirements
Module: palette_ctrl

---
 rtl/palette_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_palette_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ctrl.sv
// palette_ctrl: arbitrates host writes, host reads, display reads and an
// optional range-fill engine onto a single-port-write / single-port-read
// palette RAM. The fill engine is compiled in only when PALETTE_FILL_EN is
// defined; otherwise fill_busy_o/fill_done_o are tied low and fill inputs
// are ignored.
module palette_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_wr_req_i,
    input  logic [7:0]  host_addr_i,
    input  logic [1:0]  host_ben_i,
    input  logic [15:0] host_wdata_i,
    output logic        host_wr_ack_o,
    input  logic        host_rd_req_i,
    output logic        host_rd_ack_o,
    output logic [15:0] host_rd_data_o,
    input  logic        disp_rd_en_i,
    input  logic [7:0]  disp_addr_i,
    input  logic        fill_start_i,
    input  logic [7:0]  fill_first_i,
    input  logic [7:0]  fill_last_i,
    input  logic [15:0] fill_color_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    output logic        pal_wr_en_o,
    output logic [1:0]  pal_ben_o,
    output logic [7:0]  pal_wr_addr_o,
    output logic [15:0] pal_wr_data_o,
    output logic [7:0]  pal_rd_addr_o,
    input  logic [15:0] pal_rd_data_i
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BEN_W  = 2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;

    // Host write acceptance: never in the ack cycle
    logic host_acc_c;
    logic wr_ack_q, wr_ack_d;
    assign host_acc_c = host_wr_req_i & ~wr_ack_q;

    // Fill engine write request into the write arbiter
    logic              fill_wr_c;
    logic [ADDR_W-1:0] fill_addr_c;
    logic [DATA_W-1:0] fill_data_c;

`ifdef PALETTE_FILL_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]        fstate_q, fstate_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Fill FSM next state; yields to a host write accepted this cycle
    always_comb begin
        fstate_d  = fstate_q;
        cur_d     = cur_q;
        last_d    = last_q;
        color_d   = color_q;
        done_d    = 1'b0;
        fill_wr_c = 1'b0;
        case (fstate_q)
            S_IDLE: begin
                if (fill_start_i) begin
                    if (fill_first_i > fill_last_i) begin
                        done_d = 1'b1;
                    end else begin
                        fstate_d = S_FILL;
                        cur_d    = fill_first_i;
                        last_d   = fill_last_i;
                        color_d  = fill_color_i;
                    end
                end
            end
            S_FILL: begin
                if (!host_acc_c) begin
                    fill_wr_c = 1'b1;
                    if (cur_q == last_q) begin
                        fstate_d = S_IDLE;
                        done_d   = 1'b1;
                    end else begin
                        cur_d = cur_q + ADDR_W'(1);
                    end
                end
            end
            default: fstate_d = S_IDLE;
        endcase
        busy_d = (fstate_d == S_FILL);
    end

    // Fill FSM state and status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fstate_q <= S_IDLE;
            cur_q    <= '0;
            last_q   <= '0;
            color_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            color_q  <= color_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fill_addr_c = cur_q;
    assign fill_data_c = color_q;
    assign fill_busy_o = busy_q;
    assign fill_done_o = done_q;
`else
    logic unused_fill_c;
    assign unused_fill_c = ^{fill_start_i, fill_first_i, fill_last_i, fill_color_i};
    assign fill_wr_c     = 1'b0;
    assign fill_addr_c   = '0;
    assign fill_data_c   = '0;
    assign fill_busy_o   = 1'b0;
    assign fill_done_o   = 1'b0;
`endif

    logic              wr_en_q, wr_en_d;
    logic [BEN_W-1:0]  ben_q, ben_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Write arbiter: host has priority over the fill engine
    always_comb begin
        wr_ack_d = host_acc_c;
        wr_en_d  = 1'b0;
        ben_d    = ben_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (host_acc_c) begin
            wr_en_d = 1'b1;
            ben_d   = host_ben_i;
            waddr_d = host_addr_i;
            wdata_d = host_wdata_i;
        end else if (fill_wr_c) begin
            wr_en_d = 1'b1;
            ben_d   = BEN_W'(2'b11);
            waddr_d = fill_addr_c;
            wdata_d = fill_data_c;
        end
    end

    // Registered RAM write port and host write ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ack_q <= 1'b0;
            wr_en_q  <= 1'b0;
            ben_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ack_q <= wr_ack_d;
            wr_en_q  <= wr_en_d;
            ben_q    <= ben_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign host_wr_ack_o = wr_ack_q;
    assign pal_wr_en_o   = wr_en_q;
    assign pal_ben_o     = ben_q;
    assign pal_wr_addr_o = waddr_q;
    assign pal_wr_data_o = wdata_q;

    // Read address mux: display always owns the read port when enabled
    always_comb begin
        pal_rd_addr_o = disp_rd_en_i ? disp_addr_i : host_addr_i;
    end

    logic [1:0]        rstate_q, rstate_d;
    logic              rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Host read FSM: issue when display idle, capture one cycle later, ack
    always_comb begin
        rstate_d  = rstate_q;
        rd_ack_d  = 1'b0;
        rd_data_d = rd_data_q;
        case (rstate_q)
            R_IDLE: begin
                if (host_rd_req_i && !disp_rd_en_i) begin
                    rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                rd_data_d = pal_rd_data_i;
                rd_ack_d  = 1'b1;
                rstate_d  = R_ACK;
            end
            R_ACK:   rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Host read FSM state, ack and held read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstate_q  <= R_IDLE;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rstate_q  <= rstate_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign host_rd_ack_o  = rd_ack_q;
    assign host_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_palette_ctrl.sv
// tb_palette_ctrl: table-driven host write/read vectors plus hand-written
// fill, arbitration and reset sequences. A behavioural RAM sits on the
// palette port; observed writes are matched in order against a queue of
// expected writes. Fill sequences are built when PALETTE_FILL_EN is defined.
module tb_palette_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        host_wr_req_i = 1'b0;
    logic [7:0]  host_addr_i = '0;
    logic [1:0]  host_ben_i = '0;
    logic [15:0] host_wdata_i = '0;
    logic        host_wr_ack_o;
    logic        host_rd_req_i = 1'b0;
    logic        host_rd_ack_o;
    logic [15:0] host_rd_data_o;
    logic        disp_rd_en_i = 1'b0;
    logic [7:0]  disp_addr_i = '0;
    logic        fill_start_i = 1'b0;
    logic [7:0]  fill_first_i = '0;
    logic [7:0]  fill_last_i = '0;
    logic [15:0] fill_color_i = '0;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        pal_wr_en_o;
    logic [1:0]  pal_ben_o;
    logic [7:0]  pal_wr_addr_o;
    logic [15:0] pal_wr_data_o;
    logic [7:0]  pal_rd_addr_o;
    logic [15:0] pal_rd_data_i = '0;

    palette_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .host_wr_req_i  (host_wr_req_i),
        .host_addr_i    (host_addr_i),
        .host_ben_i     (host_ben_i),
        .host_wdata_i   (host_wdata_i),
        .host_wr_ack_o  (host_wr_ack_o),
        .host_rd_req_i  (host_rd_req_i),
        .host_rd_ack_o  (host_rd_ack_o),
        .host_rd_data_o (host_rd_data_o),
        .disp_rd_en_i   (disp_rd_en_i),
        .disp_addr_i    (disp_addr_i),
        .fill_start_i   (fill_start_i),
        .fill_first_i   (fill_first_i),
        .fill_last_i    (fill_last_i),
        .fill_color_i   (fill_color_i),
        .fill_busy_o    (fill_busy_o),
        .fill_done_o    (fill_done_o),
        .pal_wr_en_o    (pal_wr_en_o),
        .pal_ben_o      (pal_ben_o),
        .pal_wr_addr_o  (pal_wr_addr_o),
        .pal_wr_data_o  (pal_wr_data_o),
        .pal_rd_addr_o  (pal_rd_addr_o),
        .pal_rd_data_i  (pal_rd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [1:0]  ben;
        logic [15:0] data;
        logic [15:0] rd_exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   rd_ack_cnt = 0;
    logic done_wr = 1'b0;

    logic [15:0] mem [256] = '{default: 16'h0000};

    // Behavioural palette RAM: byte-enabled write, 1-cycle read latency
    always @(posedge clk) begin
        pal_rd_data_i <= mem[pal_rd_addr_o];
        if (pal_wr_en_o === 1'b1) begin
            if (pal_ben_o[0]) mem[pal_wr_addr_o][7:0]  <= pal_wr_data_o[7:0];
            if (pal_ben_o[1]) mem[pal_wr_addr_o][15:8] <= pal_wr_data_o[15:8];
        end
    end

    // Monitor: record observed writes and status pulses mid-cycle
    always @(negedge clk) begin
        if (pal_wr_en_o === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            obs_q.push_back({pal_wr_addr_o, pal_ben_o, pal_wr_data_o});
        end
        if (fill_done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_wr  <= pal_wr_en_o;
        end
        if (fill_busy_o === 1'b1) busy_cnt <= busy_cnt + 1;
        if (host_rd_ack_o === 1'b1) rd_ack_cnt <= rd_ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Match observed writes against expected writes in program order
    task automatic drain(input string name);
        logic [25:0] o;
        logic [25:0] e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected_write: got addr=0x%0h ben=%0b data=0x%0h, required none",
                         name, o[25:18], o[17:16], o[15:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s wr_payload: got 0x%0h, required 0x%0h", name, o, e);
                end
            end
        end
        chk({name, " missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Host write with full handshake; starts and ends just after a posedge
    task automatic host_write(input logic [7:0] a, input logic [1:0] b, input logic [15:0] d);
        host_addr_i   = a;
        host_ben_i    = b;
        host_wdata_i  = d;
        host_wr_req_i = 1'b1;
        exp_q.push_back({a, b, d});
        @(negedge clk);
        chk("wr_ack_early", 32'(host_wr_ack_o), 32'd0);
        tick();
        @(negedge clk);
        chk("wr_ack_pulse", 32'({host_wr_ack_o, pal_wr_en_o}), 32'b11);
        tick();
        host_wr_req_i = 1'b0;
        @(negedge clk);
        chk("wr_ack_single", 32'(host_wr_ack_o), 32'd0);
        tick();
    endtask

    // Host read with display idle; ack two cycles after request
    task automatic host_read(input logic [7:0] a, input logic [15:0] e);
        host_addr_i   = a;
        host_rd_req_i = 1'b1;
        @(negedge clk);
        chk("rd_addr_host", 32'(pal_rd_addr_o), 32'(a));
        tick();
        @(negedge clk);
        chk("rd_ack_early", 32'(host_rd_ack_o), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_ack", 32'(host_rd_ack_o), 32'd1);
        chk("rd_data", 32'(host_rd_data_o), 32'(e));
        tick();
        host_rd_req_i = 1'b0;
        @(negedge clk);
        chk("rd_ack_single", 32'(host_rd_ack_o), 32'd0);
        chk("rd_data_hold", 32'(host_rd_data_o), 32'(e));
        tick();
    endtask

    task automatic start_fill(input logic [7:0] f, input logic [7:0] l, input logic [15:0] c);
        fill_first_i = f;
        fill_last_i  = l;
        fill_color_i = c;
        fill_start_i = 1'b1;
        tick();
        fill_start_i = 1'b0;
    endtask

    task automatic fill_expect(input logic [7:0] f, input logic [7:0] l, input logic [15:0] c);
        for (int a = int'(f); a <= int'(l); a++) exp_q.push_back({8'(a), 2'b11, c});
    endtask

    task automatic check_fill(input string name, input int d0, input int b0, input int w0,
                              input int d_exp, input int b_exp, input int w_exp,
                              input logic dw_exp);
        @(negedge clk);
        #1;
        chk({name, " done_cnt"}, 32'(done_cnt - d0), 32'(d_exp));
        chk({name, " busy_cycles"}, 32'(busy_cnt - b0), 32'(b_exp));
        chk({name, " write_cnt"}, 32'(wr_cnt - w0), 32'(w_exp));
        if (d_exp > 0) chk({name, " done_with_write"}, 32'(done_wr), 32'(dw_exp));
        drain(name);
        tick();
    endtask

    initial begin
        vec_t vt[5];
        int   d0, b0, w0, r0, n;

        vt[0] = '{8'h10, 2'b10, 16'hABCD, 16'hAB00};
        vt[1] = '{8'h00, 2'b11, 16'h1234, 16'h1234};
        vt[2] = '{8'hFF, 2'b01, 16'hBEEF, 16'h00EF};
        vt[3] = '{8'h40, 2'b11, 16'h5A5A, 16'h5A5A};
        vt[4] = '{8'h7F, 2'b00, 16'hFFFF, 16'h0000};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr_port", 32'({pal_wr_en_o, pal_ben_o, pal_wr_addr_o, pal_wr_data_o}), 32'd0);
        chk("rst_status", 32'({host_wr_ack_o, host_rd_ack_o, fill_busy_o, fill_done_o}), 32'd0);
        chk("rst_rd_data", 32'(host_rd_data_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Table: host writes, then read each entry back
        for (int i = 0; i < 5; i++) host_write(vt[i].addr, vt[i].ben, vt[i].data);
        drain("host_writes");
        for (int i = 0; i < 5; i++) host_read(vt[i].addr, vt[i].rd_exp);

        // Display holds the read port for 5 cycles; host read waits
        host_addr_i   = 8'h40;
        host_rd_req_i = 1'b1;
        disp_rd_en_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            disp_addr_i = 8'(k * 16 + 3);
            @(negedge clk);
            chk("stall_rd_addr_disp", 32'(pal_rd_addr_o), 32'(k * 16 + 3));
            chk("stall_no_ack", 32'(host_rd_ack_o), 32'd0);
            tick();
        end
        disp_rd_en_i = 1'b0;
        @(negedge clk);
        chk("stall_rd_addr_host", 32'(pal_rd_addr_o), 32'h40);
        chk("stall_ack_c0", 32'(host_rd_ack_o), 32'd0);
        tick();
        @(negedge clk);
        chk("stall_ack_c1", 32'(host_rd_ack_o), 32'd0);
        tick();
        @(negedge clk);
        chk("stall_ack_c2", 32'(host_rd_ack_o), 32'd1);
        chk("stall_rd_data", 32'(host_rd_data_o), 32'h5A5A);
        tick();
        host_rd_req_i = 1'b0;
        tick();

        // Reset during a host read aborts it with no ack
        r0 = rd_ack_cnt;
        host_addr_i   = 8'h10;
        host_rd_req_i = 1'b1;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i         = 1'b0;
        host_rd_req_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk("rd_rst_no_ack", 32'(rd_ack_cnt - r0), 32'd0);
        chk("rd_rst_data_clr", 32'(host_rd_data_o), 32'd0);
        tick();

`ifdef PALETTE_FILL_EN
        // Fill to the top of the address space, no wrap
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        fill_expect(8'hFC, 8'hFF, 16'h0F00);
        start_fill(8'hFC, 8'hFF, 16'h0F00);
        repeat (8) tick();
        check_fill("fill_top", d0, b0, w0, 1, 4, 4, 1'b1);
        host_read(8'hFF, 16'h0F00);

        // Host write held from fill start lands first, fill overwrites it
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        exp_q.push_back({8'h03, 2'b11, 16'hBEEF});
        fill_expect(8'h00, 8'h07, 16'h1111);
        host_addr_i   = 8'h03;
        host_ben_i    = 2'b11;
        host_wdata_i  = 16'hBEEF;
        host_wr_req_i = 1'b1;
        start_fill(8'h00, 8'h07, 16'h1111);
        @(negedge clk);
        chk("fill_host_ack", 32'(host_wr_ack_o), 32'd1);
        tick();
        host_wr_req_i = 1'b0;
        repeat (12) tick();
        check_fill("fill_host_first", d0, b0, w0, 1, 8, 9, 1'b1);
        host_read(8'h03, 16'h1111);

        // Host write mid-fill stalls the fill for one cycle
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        fill_expect(8'h30, 8'h31, 16'h2222);
        exp_q.push_back({8'h80, 2'b01, 16'h00C3});
        fill_expect(8'h32, 8'h37, 16'h2222);
        start_fill(8'h30, 8'h37, 16'h2222);
        tick();
        tick();
        host_addr_i   = 8'h80;
        host_ben_i    = 2'b01;
        host_wdata_i  = 16'h00C3;
        host_wr_req_i = 1'b1;
        tick();
        tick();
        host_wr_req_i = 1'b0;
        repeat (10) tick();
        check_fill("fill_host_mid", d0, b0, w0, 1, 9, 9, 1'b1);

        // Empty range: done next cycle, no writes, never busy
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        start_fill(8'h20, 8'h10, 16'h7777);
        @(negedge clk);
        chk("fill_empty_done", 32'({fill_done_o, fill_busy_o}), 32'b10);
        tick();
        repeat (4) tick();
        check_fill("fill_empty", d0, b0, w0, 1, 0, 0, 1'b0);

        // Single entry
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        fill_expect(8'h55, 8'h55, 16'h3333);
        start_fill(8'h55, 8'h55, 16'h3333);
        repeat (5) tick();
        check_fill("fill_single", d0, b0, w0, 1, 1, 1, 1'b1);

        // Start while busy is ignored
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        fill_expect(8'h60, 8'h63, 16'h4444);
        start_fill(8'h60, 8'h63, 16'h4444);
        start_fill(8'h00, 8'h00, 16'hFFFF);
        repeat (8) tick();
        check_fill("fill_restart_ignored", d0, b0, w0, 1, 4, 4, 1'b1);

        // Reset once entry 0x05 of 0x00..0x0F is on the write port
        d0 = done_cnt; w0 = wr_cnt;
        fill_expect(8'h00, 8'h05, 16'h5555);
        start_fill(8'h00, 8'h0F, 16'h5555);
        n = 0;
        while ((wr_cnt - w0) < 6 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("fill_rst_reach", 32'(wr_cnt - w0), 32'd6);
        rst_i = 1'b1;
        tick();
        b0 = busy_cnt;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("fill_rst_busy", 32'(fill_busy_o), 32'd0);
        repeat (10) tick();
        check_fill("fill_rst", d0, b0, w0, 0, 0, 6, 1'b0);
`else
        // Fill engine absent: fill_start_i has no effect
        d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
        start_fill(8'h00, 8'h0F, 16'h1234);
        @(negedge clk);
        chk("nofill_busy", 32'({fill_busy_o, fill_done_o}), 32'd0);
        repeat (20) tick();
        check_fill("nofill", d0, b0, w0, 0, 0, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
